// File: rtl/market_msg_parser.sv
// market_msg_parser
//   Parses length-prefixed market messages from a DATA_W-bit valid/ready
//   stream, keeps only messages of type TYPE_A or TYPE_B, and presents one
//   registered record (type, symbol, price, qty) per kept message on a
//   valid/ready output. Saturating counters track emitted records and
//   malformed (len < 3) messages.
//
//   Header word: {type[7:0], len[7:0], symbol[DATA_W-17:0]}; len counts all
//   words including the header. Word1 = price, word2 = qty, rest ignored.
//
// Ports
//   clk, reset          clock, synchronous active-high reset
//   in_data/in_valid    input word stream
//   in_ready            parser accepts in_data this cycle
//   out_type/symbol/price/qty, out_valid, out_ready   record output
//   msg_count           records emitted (saturating)
//   err_count           malformed messages (saturating)
module market_msg_parser #(
  parameter int          DATA_W = 32,
  parameter logic [7:0]  TYPE_A = 8'h41,
  parameter logic [7:0]  TYPE_B = 8'h54,
  parameter int          CNT_W  = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [DATA_W-1:0]    in_data,
  input  logic                 in_valid,
  output logic                 in_ready,
  output logic [7:0]           out_type,
  output logic [DATA_W-17:0]   out_symbol,
  output logic [DATA_W-1:0]    out_price,
  output logic [DATA_W-1:0]    out_qty,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [CNT_W-1:0]     msg_count,
  output logic [CNT_W-1:0]     err_count
);

  localparam int SYM_W = DATA_W - 16;

  typedef enum logic [1:0] {HDR, PRICE, QTY, SKIP} state_t;

  state_t state, state_next;
  logic [7:0] skip, skip_next;

  logic [7:0]        sh_type;
  logic [SYM_W-1:0]  sh_symbol;
  logic [7:0]        sh_len;
  logic [DATA_W-1:0] sh_price;

  logic [7:0]       hdr_type;
  logic [7:0]       hdr_len;
  logic [SYM_W-1:0] hdr_symbol;
  logic             xfer;
  logic             hdr_accept;
  logic             err_inc;
  logic             emit;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    if (v == {CNT_W{1'b1}})
      return v;
    else
      return v + {{(CNT_W-1){1'b0}}, 1'b1};
  endfunction

  assign hdr_type   = in_data[DATA_W-1 -: 8];
  assign hdr_len    = in_data[DATA_W-9 -: 8];
  assign hdr_symbol = in_data[SYM_W-1:0];

  // Only the qty word must wait for the output register to free up; header,
  // price and tail words keep flowing so the next message is pre-parsed.
  assign in_ready   = !(state == QTY && out_valid && !out_ready);
  assign xfer       = in_valid && in_ready;
  assign hdr_accept = (hdr_type == TYPE_A) || (hdr_type == TYPE_B);
  assign err_inc    = (state == HDR) && xfer && (hdr_len < 8'd3);
  assign emit       = (state == QTY) && xfer;

  always_comb begin
    state_next = state;
    skip_next  = skip;
    case (state)
      HDR: begin
        if (xfer) begin
          if (hdr_len < 8'd3) begin
            // len 0/1 has no body to drain; len 2 has one body word
            if (hdr_len >= 8'd2) begin
              skip_next  = hdr_len - 8'd1;
              state_next = SKIP;
            end
          end else if (hdr_accept) begin
            state_next = PRICE;
          end else begin
            skip_next  = hdr_len - 8'd1;
            state_next = SKIP;
          end
        end
      end
      PRICE: begin
        if (xfer) state_next = QTY;
      end
      QTY: begin
        if (xfer) begin
          if (sh_len == 8'd3) begin
            state_next = HDR;
          end else begin
            skip_next  = sh_len - 8'd3;
            state_next = SKIP;
          end
        end
      end
      SKIP: begin
        if (xfer) begin
          if (skip == 8'd1) state_next = HDR;
          else              skip_next  = skip - 8'd1;
        end
      end
      default: state_next = HDR;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= HDR;
      skip       <= 8'd0;
      out_valid  <= 1'b0;
      out_type   <= 8'd0;
      out_symbol <= '0;
      out_price  <= '0;
      out_qty    <= '0;
      msg_count  <= '0;
      err_count  <= '0;
    end else begin
      state <= state_next;
      skip  <= skip_next;
      if (err_inc) err_count <= sat_inc(err_count);
      // A load in the same cycle as a hand-off wins, giving zero-bubble reload.
      if (out_valid && out_ready) out_valid <= 1'b0;
      if (emit) begin
        out_valid  <= 1'b1;
        out_type   <= sh_type;
        out_symbol <= sh_symbol;
        out_price  <= sh_price;
        out_qty    <= in_data;
        msg_count  <= sat_inc(msg_count);
      end
    end
  end

  // Shadow registers are pure data; the FSM decides when they are meaningful.
  always_ff @(posedge clk) begin
    if (state == HDR && xfer && hdr_accept && hdr_len >= 8'd3) begin
      sh_type   <= hdr_type;
      sh_symbol <= hdr_symbol;
      sh_len    <= hdr_len;
    end
    if (state == PRICE && xfer) sh_price <= in_data;
  end

endmodule

// File: tb/tb_market_msg_parser.sv
module tb_market_msg_parser;

  localparam int DATA_W = 32;
  localparam int CNT_W  = 3;

  logic              clk = 1'b0;
  logic              reset;
  logic [DATA_W-1:0] in_data;
  logic              in_valid;
  logic              in_ready;
  logic [7:0]        out_type;
  logic [15:0]       out_symbol;
  logic [DATA_W-1:0] out_price;
  logic [DATA_W-1:0] out_qty;
  logic              out_valid;
  logic              out_ready;
  logic [CNT_W-1:0]  msg_count;
  logic [CNT_W-1:0]  err_count;

  int total  = 0;
  int passed = 0;
  int failed = 0;

  market_msg_parser #(
    .DATA_W(DATA_W), .TYPE_A(8'h41), .TYPE_B(8'h54), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .reset(reset),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .out_type(out_type), .out_symbol(out_symbol), .out_price(out_price),
    .out_qty(out_qty), .out_valid(out_valid), .out_ready(out_ready),
    .msg_count(msg_count), .err_count(err_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [DATA_W-1:0] w);
    in_data  = w;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic check_rec(input string tag, input logic [7:0] t, input logic [15:0] s,
                           input logic [31:0] p, input logic [31:0] q, input logic [2:0] mc);
    check({tag, "_valid"}, out_valid, 1'b1);
    check({tag, "_type"},  out_type,  t);
    check({tag, "_sym"},   out_symbol, s);
    check({tag, "_price"}, out_price, p);
    check({tag, "_qty"},   out_qty,   q);
    check({tag, "_msgcnt"}, msg_count, mc);
  endtask

  initial begin
    reset = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
    tick(); tick();
    reset = 1'b0;
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_msg_count", msg_count, 3'd0);
    check("rst_err_count", err_count, 3'd0);
    check("rst_in_ready",  in_ready,  1'b1);
    check("rst_out_price", out_price, 32'd0);

    // 1: basic 3-word 'A' message, record one cycle after qty
    send(32'h4103_ABCD);
    send(32'h0000_1388);
    check("t1_no_early_valid", out_valid, 1'b0);
    send(32'h0000_0064);
    check_rec("t1", 8'h41, 16'hABCD, 32'h1388, 32'h64, 3'd1);
    tick();
    check("t1_handoff", out_valid, 1'b0);

    // 2: 5-word 'T' message, two tail words drained, next header parsed
    send(32'h5405_1234);
    send(32'h0000_2222);
    send(32'h0000_3333);
    check_rec("t2", 8'h54, 16'h1234, 32'h2222, 32'h3333, 3'd2);
    send(32'h4103_FFFF);   // tail word that looks like a header
    send(32'h0000_7777);   // last tail word
    check("t2_tail_no_rec", out_valid, 1'b0);
    send(32'h4103_0001);
    send(32'h0000_0010);
    send(32'h0000_0020);
    check_rec("t2b", 8'h41, 16'h0001, 32'h10, 32'h20, 3'd3);

    // 3: filtered type 'X', 4 words total
    send(32'h5804_BEEF);
    send(32'h0000_0001);
    send(32'h0000_0002);
    send(32'h0000_0003);
    check("t3_no_rec", out_valid, 1'b0);
    check("t3_msgcnt", msg_count, 3'd3);
    check("t3_errcnt", err_count, 3'd0);
    send(32'h4103_0002);
    send(32'h0000_00AA);
    send(32'h0000_00BB);
    check_rec("t3b", 8'h41, 16'h0002, 32'hAA, 32'hBB, 3'd4);

    // 4: malformed len 2 (+1 body word) and len 0
    send(32'h4102_0000);
    send(32'h0000_0099);
    send(32'h4100_0000);
    check("t4_errcnt", err_count, 3'd2);
    check("t4_no_rec", out_valid, 1'b0);
    send(32'h4103_0003);
    send(32'h0000_0005);
    send(32'h0000_0006);
    check_rec("t4b", 8'h41, 16'h0003, 32'h5, 32'h6, 3'd5);

    // 5: backpressure, second qty stalls then reloads in the hand-off cycle
    tick();
    out_ready = 1'b0;
    send(32'h4103_0011);
    send(32'h0000_0100);
    send(32'h0000_0200);
    check_rec("t5a", 8'h41, 16'h0011, 32'h100, 32'h200, 3'd6);
    send(32'h4103_0022);
    send(32'h0000_0300);
    in_data = 32'h0000_0400; in_valid = 1'b1;
    #1;
    check("t5_in_ready_low", in_ready, 1'b0);
    tick();
    check_rec("t5_held", 8'h41, 16'h0011, 32'h100, 32'h200, 3'd6);
    out_ready = 1'b1;
    #1;
    check("t5_in_ready_high", in_ready, 1'b1);
    tick();
    in_valid = 1'b0;
    check_rec("t5b", 8'h41, 16'h0022, 32'h300, 32'h400, 3'd7);
    tick();
    check("t5_drain", out_valid, 1'b0);

    // 6: counter saturation, then reset during PRICE with a record pending
    out_ready = 1'b0;
    send(32'h4103_0033);
    send(32'h0000_0500);
    send(32'h0000_0600);
    check_rec("t6_sat", 8'h41, 16'h0033, 32'h500, 32'h600, 3'd7);
    send(32'h4103_0044);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("t6_rst_valid",  out_valid, 1'b0);
    check("t6_rst_msgcnt", msg_count, 3'd0);
    check("t6_rst_errcnt", err_count, 3'd0);
    check("t6_rst_qty",    out_qty,   32'd0);
    out_ready = 1'b1;
    send(32'h4103_0055);
    send(32'h0000_0700);
    send(32'h0000_0800);
    check_rec("t6b", 8'h41, 16'h0055, 32'h700, 32'h800, 3'd1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
